// File: rtl/aes_req_arbiter.sv
// Two-requester round-robin front end for an iterative AES core: grants a job, loads key,
// starts the core, waits CORE_LATENCY cycles and returns the ciphertext. Define AES_ARB_KEY_CACHE_EN to skip reloading a repeated key.
module aes_req_arbiter #(
  parameter int CORE_LATENCY = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [127:0] req0_pt,
  input  logic [127:0] req1_pt,
  input  logic [127:0] req0_key,
  input  logic [127:0] req1_key,
  output logic [1:0]   resp_valid,
  input  logic [1:0]   resp_ready,
  output logic [127:0] resp_ct,
  output logic [127:0] core_plain_text,
  output logic [127:0] core_key_in,
  output logic         core_set_new_key,
  output logic         core_start,
  output logic         core_restart,
  input  logic [127:0] core_cipher_text,
  output logic         busy
);

  localparam int CNT_W = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_KEY, START, WAIT, RESP} state_t;

  state_t             state;
  logic               grant;
  logic               last_grant;
  logic [CNT_W-1:0]   wait_cnt;
  logic               grant_idx;
  logic [127:0]       sel_key;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_idx = req_valid[1];
    if (req_valid == 2'b11) grant_idx = ~last_grant;
    sel_key = grant_idx ? req1_key : req0_key;
  end

`ifdef AES_ARB_KEY_CACHE_EN
  logic         cache_valid;
  logic [127:0] cached_key;
  logic         cache_hit;

  assign cache_hit = cache_valid && (sel_key == cached_key);

  // NOTE: the key store carries no reset; cache_valid gates every use of it.
  always_ff @(posedge clk) begin
    if (state == LOAD_KEY) cached_key <= core_key_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      grant            <= 1'b0;
      last_grant       <= 1'b1;
      wait_cnt         <= '0;
      req_ready        <= '0;
      resp_valid       <= '0;
      resp_ct          <= '0;
      core_plain_text  <= '0;
      core_key_in      <= '0;
      core_set_new_key <= 1'b0;
      core_start       <= 1'b0;
`ifdef AES_ARB_KEY_CACHE_EN
      cache_valid      <= 1'b0;
`endif
    end else begin
      // NOTE: pulses default low with non-blocking assignments; a later assignment in the case wins.
      req_ready        <= '0;
      core_set_new_key <= 1'b0;
      core_start       <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant           <= grant_idx;
            last_grant      <= grant_idx;
            req_ready       <= grant_idx ? 2'b10 : 2'b01;
            core_plain_text <= grant_idx ? req1_pt : req0_pt;
            core_key_in     <= sel_key;
`ifdef AES_ARB_KEY_CACHE_EN
            if (cache_hit) begin
              state      <= START;
              core_start <= 1'b1;
            end else begin
              state            <= LOAD_KEY;
              core_set_new_key <= 1'b1;
            end
`else
            state            <= LOAD_KEY;
            core_set_new_key <= 1'b1;
`endif
          end
        end
        LOAD_KEY: begin
          state      <= START;
          core_start <= 1'b1;
`ifdef AES_ARB_KEY_CACHE_EN
          cache_valid <= 1'b1;
`endif
        end
        START: begin
          wait_cnt <= CNT_W'(CORE_LATENCY - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            resp_ct    <= core_cipher_text;
            resp_valid <= grant ? 2'b10 : 2'b01;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          // Only the granted requester's ready completes the handshake.
          if (resp_ready[grant]) begin
            resp_valid <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign core_restart = 1'b0;

endmodule

// File: doc/aes_req_arbiter.md
AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 SHALL have parameter CORE_LATENCY, default 11: cycles from core_start pulse to valid core_cipher_text.
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  2  per-requester job request (bit i = requester i).
REQ-005 SHALL have port req_ready  output  2  one-cycle job-accept pulse per requester.
REQ-006 SHALL have port req0_pt / req1_pt  input  128 each  plaintext per requester.
REQ-007 SHALL have port req0_key / req1_key  input  128 each  key per requester.
REQ-008 SHALL have port resp_valid  output  2  ciphertext valid per requester.
REQ-009 SHALL have port resp_ready  input  2  response accept per requester.
REQ-010 SHALL have port resp_ct  output  128  captured ciphertext, shared.
REQ-011 SHALL have core-side ports core_plain_text, core_key_in (output 128), core_set_new_key, core_start, core_restart (output 1), core_cipher_text (input 128).
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD_KEY, START, WAIT, RESP.
REQ-014 IDLE: if any req_valid, grant round-robin (non-last-granted requester wins a tie), pulse req_ready[g], latch its pt/key, go LOAD_KEY.
REQ-015 LOAD_KEY: drive core_key_in = latched key, core_set_new_key = 1 for exactly one cycle, go START.
REQ-016 START: drive core_plain_text = latched pt, core_start = 1 for exactly one cycle, load wait counter with CORE_LATENCY-1, go WAIT.
REQ-017 WAIT: decrement counter each cycle; at 0 capture core_cipher_text into resp_ct, go RESP.
REQ-018 RESP: hold resp_valid[g] = 1 and resp_ct stable until resp_ready[g]; on handshake clear resp_valid and go IDLE same edge.
REQ-019 core_plain_text and core_key_in SHALL hold latched values from LOAD_KEY through WAIT.
REQ-020 core_restart SHALL be driven constant 0.
REQ-021 Requests arriving outside IDLE SHALL wait; req_valid must stay high until req_ready (no loss, no duplicate).
REQ-022 resp_ready on non-granted bit SHALL be ignored; at most one resp_valid bit high.
REQ-023 Latency (key reload) SHALL be grant + 2 + CORE_LATENCY cycles to resp_valid.

Reset
REQ-024 On reset_n = 0 at clk edge: state IDLE, req_ready/resp_valid = 0, core_start/core_set_new_key = 0, resp_ct = 0, last-grant = 1 (requester 0 wins first tie), key-cache valid = 0; in-flight job dropped, no response.

Configuration
REQ-025 Macro AES_ARB_KEY_CACHE_EN: when defined, SHALL store last loaded key plus valid flag; IDLE grant with matching key and flag set SHALL bypass LOAD_KEY (IDLE -> START), latency grant + 1 + CORE_LATENCY.
REQ-026 When undefined, SHALL always pass through LOAD_KEY; no key storage.

Verification
REQ-027 Single job: req_valid=01, key 2b7e151628aed2a6abf7158809cf4f3c, pt 89c2abb23688ac1c675eb2d4cf2a263e -> one set_new_key pulse, one start pulse, resp_valid=01 after 13 cycles, resp_ct = model ciphertext.
REQ-028 Simultaneous req_valid=11 after reset -> requester 0 served first, then 1; next tie -> 0 again only after 1 served.
REQ-029 Back-pressure: resp_ready held 0 for 20 cycles -> resp_valid/resp_ct stable, busy=1, pending request not accepted.
REQ-030 Reset asserted during WAIT -> next cycle IDLE, all outputs zero, no resp_valid ever for dropped job.
REQ-031 AES_ARB_KEY_CACHE_EN defined, two jobs same key -> second has no set_new_key pulse, latency 12; different key -> pulse present.
REQ-032 resp_ready=10 while resp_valid=01 -> ignored, state stays RESP.
